// File: rtl/ac97_cmd_arbiter.sv
// ac97_cmd_arbiter: two-requester, frame-synchronous arbiter for AC97 codec register commands.
// Read-back tracking (WAIT_RD state, response timeout) exists only when AC97_READBACK_EN is defined.
module ac97_cmd_arbiter #(
   parameter int unsigned ReadTimeoutFrames = 4
) (
   input  logic        i_ac97_bit_clock,
   input  logic        i_reset,
   input  logic        i_frame_start,
   input  logic [1:0]  i_req,
   input  logic [1:0]  i_rd_wr,
   input  logic [6:0]  i_addr0,
   input  logic [6:0]  i_addr1,
   input  logic [15:0] i_data0,
   input  logic [15:0] i_data1,
   input  logic        i_status_valid,
   input  logic [6:0]  i_status_addr,
   input  logic [15:0] i_status_data,
   output logic [1:0]  o_ack,
   output logic [19:0] o_slot_addr,
   output logic [19:0] o_slot_data,
   output logic        o_slot_valid,
   output logic [1:0]  o_rd_valid,
   output logic [15:0] o_rd_data,
   output logic        o_rd_timeout,
   output logic        o_busy
);

`ifdef AC97_READBACK_EN
   typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;
   localparam logic [3:0] TimeoutLast = 4'(ReadTimeoutFrames - 1);
`else
   typedef enum logic [1:0] {StIdle, StIssue} state_e;
`endif

   state_e      r_state, w_state_next;
   logic        r_last, w_last_next;
   logic [1:0]  r_ack, w_ack_next;
   logic [19:0] r_slot_addr, w_slot_addr_next;
   logic [19:0] r_slot_data, w_slot_data_next;
   logic        r_slot_valid, w_slot_valid_next;

   logic        w_arb;
   logic        w_gnt_id;
   logic        w_gnt_rd;
   logic [6:0]  w_gnt_addr;
   logic [15:0] w_gnt_data;

`ifdef AC97_READBACK_EN
   logic        r_is_rd, w_is_rd_next;
   logic        r_rd_who, w_rd_who_next;
   logic [6:0]  r_rd_addr, w_rd_addr_next;
   logic [3:0]  r_cnt, w_cnt_next;
   logic [1:0]  r_rd_valid, w_rd_valid_next;
   logic [15:0] r_rd_data, w_rd_data_next;
   logic        r_rd_timeout, w_rd_timeout_next;
`else
   logic        w_unused_status;
   assign w_unused_status = ^{i_status_valid, i_status_addr, i_status_data};
`endif

   // On contention the requester not granted last wins; otherwise whoever is asking.
   always_comb begin
      w_gnt_id   = (i_req == 2'b11) ? ~r_last : i_req[1];
      w_gnt_rd   = w_gnt_id ? i_rd_wr[1] : i_rd_wr[0];
      w_gnt_addr = w_gnt_id ? i_addr1 : i_addr0;
      w_gnt_data = w_gnt_id ? i_data1 : i_data0;
   end

   always_comb begin
      w_state_next      = r_state;
      w_last_next       = r_last;
      w_ack_next        = 2'b00;
      w_slot_addr_next  = r_slot_addr;
      w_slot_data_next  = r_slot_data;
      w_slot_valid_next = r_slot_valid;
      w_arb             = 1'b0;
`ifdef AC97_READBACK_EN
      w_is_rd_next      = r_is_rd;
      w_rd_who_next     = r_rd_who;
      w_rd_addr_next    = r_rd_addr;
      w_cnt_next        = r_cnt;
      w_rd_valid_next   = 2'b00;
      w_rd_data_next    = r_rd_data;
      w_rd_timeout_next = r_rd_timeout;
`endif

      case (r_state)
         StIdle: w_arb = i_frame_start;
         StIssue: begin
`ifdef AC97_READBACK_EN
            if (i_frame_start && r_is_rd) begin
               w_state_next      = StWaitRd;
               w_cnt_next        = 4'd0;
               w_slot_addr_next  = 20'h00000;
               w_slot_data_next  = 20'h00000;
               w_slot_valid_next = 1'b0;
            end else
`endif
            w_arb = i_frame_start;
         end
`ifdef AC97_READBACK_EN
         StWaitRd: begin
            // A matching status wins over a coincident frame start, which may then arbitrate.
            if (i_status_valid && (i_status_addr == r_rd_addr)) begin
               w_rd_valid_next   = r_rd_who ? 2'b10 : 2'b01;
               w_rd_data_next    = i_status_data;
               w_rd_timeout_next = 1'b0;
               w_state_next      = StIdle;
               w_arb             = i_frame_start;
            end else if (i_frame_start) begin
               w_slot_addr_next  = 20'h00000;
               w_slot_data_next  = 20'h00000;
               w_slot_valid_next = 1'b0;
               if (r_cnt == TimeoutLast) begin
                  w_rd_valid_next   = r_rd_who ? 2'b10 : 2'b01;
                  w_rd_data_next    = 16'hFFFF;
                  w_rd_timeout_next = 1'b1;
                  w_state_next      = StIdle;
               end else begin
                  w_cnt_next = r_cnt + 4'd1;
               end
            end
         end
`endif
         default: w_state_next = StIdle;
      endcase

      if (w_arb) begin
         if (i_req != 2'b00) begin
            w_state_next      = StIssue;
            w_last_next       = w_gnt_id;
            w_ack_next        = w_gnt_id ? 2'b10 : 2'b01;
            w_slot_addr_next  = {w_gnt_rd, w_gnt_addr, 12'h000};
            w_slot_data_next  = w_gnt_rd ? 20'h00000 : {w_gnt_data, 4'h0};
            w_slot_valid_next = 1'b1;
`ifdef AC97_READBACK_EN
            w_is_rd_next      = w_gnt_rd;
            w_rd_who_next     = w_gnt_id;
            w_rd_addr_next    = w_gnt_addr;
`endif
         end else begin
            w_state_next      = StIdle;
            w_slot_addr_next  = 20'h00000;
            w_slot_data_next  = 20'h00000;
            w_slot_valid_next = 1'b0;
         end
      end
   end

   always_ff @(posedge i_ac97_bit_clock) begin
      if (i_reset) begin
         r_state      <= StIdle;
         r_last       <= 1'b1;
         r_ack        <= 2'b00;
         r_slot_addr  <= 20'h00000;
         r_slot_data  <= 20'h00000;
         r_slot_valid <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_last       <= w_last_next;
         r_ack        <= w_ack_next;
         r_slot_addr  <= w_slot_addr_next;
         r_slot_data  <= w_slot_data_next;
         r_slot_valid <= w_slot_valid_next;
      end
   end

`ifdef AC97_READBACK_EN
   always_ff @(posedge i_ac97_bit_clock) begin
      if (i_reset) begin
         r_is_rd      <= 1'b0;
         r_rd_who     <= 1'b0;
         r_rd_addr    <= 7'h00;
         r_cnt        <= 4'd0;
         r_rd_valid   <= 2'b00;
         r_rd_data    <= 16'h0000;
         r_rd_timeout <= 1'b0;
      end else begin
         r_is_rd      <= w_is_rd_next;
         r_rd_who     <= w_rd_who_next;
         r_rd_addr    <= w_rd_addr_next;
         r_cnt        <= w_cnt_next;
         r_rd_valid   <= w_rd_valid_next;
         r_rd_data    <= w_rd_data_next;
         r_rd_timeout <= w_rd_timeout_next;
      end
   end

   assign o_rd_valid   = r_rd_valid;
   assign o_rd_data    = r_rd_data;
   assign o_rd_timeout = r_rd_timeout;
`else
   assign o_rd_valid   = 2'b00;
   assign o_rd_data    = 16'h0000;
   assign o_rd_timeout = 1'b0;
`endif

   assign o_ack        = r_ack;
   assign o_slot_addr  = r_slot_addr;
   assign o_slot_data  = r_slot_data;
   assign o_slot_valid = r_slot_valid;
   assign o_busy       = (r_state != StIdle);

endmodule

// File: doc/ac97_cmd_arbiter.md
AC97_CMD_ARBITER -- requirements
Module: ac97_cmd_arbiter

Interface
REQ-001 Parameter ReadTimeoutFrames, default 4: frames to wait for a read response before timeout (legal range 1-15).
REQ-002 AC97BitClock  in  1  AC97 bit clock; the only clock; all logic updates on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 FrameStart  in  1  one-cycle pulse, once per 256-bit frame, from the frame/serializer logic.
REQ-005 Req  in  2  per-requester command request, held high until the matching Ack.
REQ-006 RdWr  in  2  per-requester direction, 1=read, 0=write.
REQ-007 Addr0, Addr1  in  7 each  codec register address per requester.
REQ-008 Data0, Data1  in  16 each  write data per requester, ignored for reads.
REQ-009 StatusValid  in  1  one-cycle pulse: a status slot was received.
REQ-010 StatusAddr  in  7  register address carried by the status slot.
REQ-011 StatusData  in  16  register data carried by the status slot.
REQ-012 Ack  out  2  one-cycle pulse, one-hot: the request was accepted.
REQ-013 SlotAddr  out  20  slot-1 word {RdWr, Addr[6:0], 12'h000}.
REQ-014 SlotData  out  20  slot-2 word {Data[15:0], 4'h0}, all zero for reads.
REQ-015 SlotValid  out  1  tag bits for slots 1 and 2 are valid this frame.
REQ-016 RdValid  out  2  one-cycle pulse, one-hot: read result for that requester.
REQ-017 RdData  out  16  read result, held until the next RdValid.
REQ-018 RdTimeout  out  1  qualifies RdValid: no matching status arrived.
REQ-019 Busy  out  1  high while state is not IDLE.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT_RD.
REQ-021 Arbitration is evaluated only in the FrameStart cycle N.
REQ-022 A grant at cycle N loads SlotAddr, SlotData and SlotValid=1 at N+1, pulses Ack at N+1 and moves the FSM to ISSUE.
REQ-023 Contention is resolved round-robin: the requester not granted last wins.
REQ-024 Without contention, the requesting side wins regardless of the pointer.
REQ-025 Slot outputs hold constant from N+1 until the next FrameStart+1.
REQ-026 A FrameStart with no grant sets SlotValid=0 and SlotAddr=SlotData=0 at N+1.
REQ-027 A granted write returns ISSUE to IDLE at the next FrameStart; that cycle also arbitrates, so back-to-back writes occupy consecutive frames.
REQ-028 A granted read moves ISSUE to WAIT_RD at the next FrameStart; that frame is idle (SlotValid=0).
REQ-029 In WAIT_RD, no request is granted and Ack stays 0.
REQ-030 In WAIT_RD, StatusValid with StatusAddr equal to the issued address produces, next cycle, RdData=StatusData, RdTimeout=0 and RdValid at the reader's bit; state returns to IDLE.
REQ-031 In WAIT_RD, a status with a non-matching address is ignored.
REQ-032 WAIT_RD counts FrameStart pulses; at count ReadTimeoutFrames: RdData=16'hFFFF, RdTimeout=1, RdValid pulses, state returns to IDLE.
REQ-033 StatusValid and FrameStart in the same cycle: the status match is evaluated first, and that FrameStart may arbitrate from IDLE.
REQ-034 A Req drop before Ack withdraws the request without error.

Reset
REQ-035 Reset sets Ack=0, RdValid=0, RdTimeout=0, SlotValid=0, SlotAddr=0, SlotData=0, RdData=0, Busy=0.
REQ-036 Reset sets the FSM to IDLE, the timeout counter to 0 and the round-robin pointer to "last=1", so requester 0 wins the first tie.
REQ-037 Reset during WAIT_RD discards the outstanding read; no RdValid pulse is produced.

Configuration
REQ-038 Macro AC97_READBACK_EN.
REQ-039 With AC97_READBACK_EN defined, read tracking behaves as REQ-028 to REQ-032.
REQ-040 Without AC97_READBACK_EN, the WAIT_RD state and the timeout counter are absent; a read returns to IDLE like a write, and RdValid, RdTimeout and RdData are tied to 0.

Verification
REQ-041 Req=2'b01 write, Addr0=7'h02, Data0=16'h1414, then FrameStart -> next cycle SlotAddr=20'h02000, SlotData=20'h14140, SlotValid=1, Ack=2'b01.
REQ-042 Both Req held across 4 FrameStarts -> grants alternate 0,1,0,1; no Ack is ever two-hot.
REQ-043 Read by requester 1 at Addr1=7'h7C, then StatusValid with StatusAddr=7'h7C, StatusData=16'h4E53 during WAIT_RD -> RdValid=2'b10, RdData=16'h4E53, RdTimeout=0.
REQ-044 Read with no matching status, ReadTimeoutFrames=4 -> RdValid after the 4th FrameStart in WAIT_RD with RdData=16'hFFFF and RdTimeout=1; Ack stays 0 throughout.
REQ-045 Reset asserted in WAIT_RD -> all outputs return to 0 next cycle, no RdValid; a subsequent write is granted on the next FrameStart.
REQ-046 Build without AC97_READBACK_EN, issue a read -> SlotAddr[19]=1, IDLE after one frame, RdValid is never asserted.
